// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: word width, length field width, FSM states, length decode.
// Latency: n/a (package).
// Backpressure: n/a (package).
package serial_pkg;

    localparam int DATA_W = 16;
    localparam int MOD_W  = $clog2(DATA_W) + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // A length field of 0 means a full word; anything beyond the word saturates to a full word.
    // A value of 1 passes through unchanged so callers can recognise and drop it.
    function automatic logic [MOD_W-1:0] mod_to_len(input logic [MOD_W-1:0] mod);
        logic [MOD_W-1:0] len;
        if (mod == '0 || mod > MOD_W'(DATA_W)) begin
            len = MOD_W'(DATA_W);
        end else begin
            len = mod;
        end
        return len;
    endfunction

endpackage

// File: rtl/serial_hold_buf.sv
// One-entry holding register for a word (data + decoded length) waiting for the shifter.
// Latency: a pushed word is visible on full_o/dat_o/len_o the cycle after the push.
// Backpressure: none internally; the owner must not push while full unless it pops in the same cycle.
module serial_hold_buf
    import serial_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic [MOD_W-1:0]  push_len_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic [DATA_W-1:0] dat_o,
    output logic [MOD_W-1:0]  len_o
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [MOD_W-1:0]  len_q, len_d;

    // Next-state: a push wins over a pop so accept-and-drain in one cycle keeps the entry full.
    always_comb begin
        full_d = full_q;
        dat_d  = dat_q;
        len_d  = len_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i) begin
            full_d = 1'b1;
            dat_d  = push_dat_i;
            len_d  = push_len_i;
        end
    end

    // Entry registers, discarded by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            dat_q  <= '0;
            len_q  <= '0;
        end else begin
            full_q <= full_d;
            dat_q  <= dat_d;
            len_q  <= len_d;
        end
    end

    assign full_o = full_q;
    assign dat_o  = dat_q;
    assign len_o  = len_q;

endmodule

// File: rtl/serial.sv
// Parallel-to-serial transmitter: shifts the top N bits of a word out MSB-first; optional
// one-entry holding buffer when SERIAL_HOLD_BUF_EN is defined.
// Latency: first bit on the cycle after accept; a word occupies exactly N cycles.
// Backpressure: ready_o low while sending (no buffer) or while the holding buffer is full.
module serial
    import serial_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ready_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_SEND = SEND;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [MOD_W-1:0]  cnt_q, cnt_d;

    logic [MOD_W-1:0]  in_len;
    logic              accept;
    logic              free;
    logic              buf_full;
    logic [DATA_W-1:0] buf_dat;
    logic [MOD_W-1:0]  buf_len;
    logic              ld_vld;
    logic [DATA_W-1:0] ld_dat;
    logic [MOD_W-1:0]  ld_len;

    assign in_len = mod_to_len(data_mod_i);
    assign accept = data_val_i && ready_o;
    // The shifter can take a new word when idle or while its last bit is on the line.
    assign free   = (state_q == S_IDLE) || (cnt_q == '0);

`ifdef SERIAL_HOLD_BUF_EN
    logic buf_push;
    logic buf_pop;

    assign ready_o  = !buf_full && !rst_i;
    assign buf_pop  = free && buf_full;
    assign buf_push = accept && (!free || buf_full);

    serial_hold_buf u_hold_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (buf_push),
        .push_dat_i (data_i),
        .push_len_i (in_len),
        .pop_i      (buf_pop),
        .full_o     (buf_full),
        .dat_o      (buf_dat),
        .len_o      (buf_len)
    );
`else
    assign ready_o  = (state_q == S_IDLE) && !rst_i;
    assign buf_full = 1'b0;
    assign buf_dat  = '0;
    assign buf_len  = '0;
`endif

    // Pick the word that loads the shifter: a held word has priority over a fresh accept.
    always_comb begin
        ld_vld = 1'b0;
        ld_dat = data_i;
        ld_len = in_len;
        if (free) begin
            if (buf_full) begin
                ld_vld = 1'b1;
                ld_dat = buf_dat;
                ld_len = buf_len;
            end else if (accept) begin
                ld_vld = 1'b1;
            end
        end
    end

    // FSM, shifter and bit counter; single-bit words are dropped by never entering SEND.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (free) begin
            if (ld_vld && ld_len >= MOD_W'(2)) begin
                state_d = S_SEND;
                shift_d = ld_dat;
                cnt_d   = ld_len - MOD_W'(1);
            end else begin
                state_d = S_IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
        end else begin
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q - MOD_W'(1);
        end
    end

    // State registers; reset aborts any word in flight and zeroes the outputs at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ser_data_val_o = (state_q == S_SEND);
    assign ser_data_o     = shift_q[DATA_W-1] && (state_q == S_SEND);
    assign busy_o         = (state_q == S_SEND) && (cnt_q != '0);

endmodule

// File: tb/tb_serial.sv
// Self-checking bench for serial: randomized and directed words against a queue-based reference.
// Latency: expects first bit one cycle after accept and N contiguous bits per word.
// Backpressure: waits on ready_o with a bounded cycle budget before each accept.
`timescale 1ns/1ps
module tb_serial;
    import serial_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] data_i = '0;
    logic [4:0]  data_mod_i = '0;
    logic        data_val_i = 1'b0;
    logic        ready_o, ser_data_o, ser_data_val_o, busy_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    bit obs_bit[$];
    bit obs_busy[$];
    int obs_cyc[$];
    bit exp_bit[$];
    bit exp_busy[$];
    bit rdy_hist[int];

    serial dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ready_o        (ready_o),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Line monitor: records every valid bit and checks the line is quiet between words.
    always @(negedge clk_i) begin
        rdy_hist[cyc] = ready_o;
        vectors++;
        if (ser_data_val_o !== 1'b1 && (ser_data_o !== 1'b0 || busy_o !== 1'b0)) begin
            miscompares++;
            $display("FAIL idle_quiet cyc=%0d: ser_data_o=%b busy_o=%b with val=%b, required 0/0",
                     cyc, ser_data_o, busy_o, ser_data_val_o);
        end
        if (ser_data_val_o === 1'b1) begin
            obs_bit.push_back(ser_data_o);
            obs_busy.push_back(busy_o);
            obs_cyc.push_back(cyc);
        end
    end

    // Reference: N from the length rules, then the top N bits MSB first, busy low only on the last.
    function automatic int model_len(input int mod);
        return (mod == 0 || mod > 16) ? 16 : mod;
    endfunction

    function automatic void model_word(input logic [15:0] d, input int mod);
        int n;
        n = model_len(mod);
        if (n < 2) return;
        for (int k = 0; k < n; k++) begin
            exp_bit.push_back(d[15-k]);
            exp_busy.push_back(k != n - 1);
        end
    endfunction

    task automatic clear_all();
        obs_bit.delete();
        obs_busy.delete();
        obs_cyc.delete();
        exp_bit.delete();
        exp_busy.delete();
    endtask

    // Offer one word; acc returns the cycle in which it was accepted.
    task automatic push_word(input logic [15:0] d, input logic [4:0] m, output bit ok, output int acc);
        ok = 1'b0;
        acc = -1;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk_i);
            if (ready_o === 1'b1) begin
                data_i = d;
                data_mod_i = m;
                data_val_i = 1'b1;
                acc = cyc;
                ok = 1'b1;
            end
        end
        if (ok) begin
            @(posedge clk_i);
            #1;
            data_val_i = 1'b0;
            data_i = 16'($urandom);
            data_mod_i = 5'($urandom);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        vectors++;
        if ({ser_data_o, ser_data_val_o, busy_o, ready_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: data/val/busy/ready=%b, required 0000",
                     {ser_data_o, ser_data_val_o, busy_o, ready_o});
        end
        rst_i = 1'b0;
        #1;
        vectors++;
        if (ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: ready_o=%b, required 1", ready_o);
        end
    endtask

    task automatic test_patterns();
        logic [15:0] pd [2] = '{16'hA5F0, 16'hC000};
        logic [4:0]  pm [2] = '{5'd0, 5'd3};
        bit ok;
        int acc;
        for (int w = 0; w < 2; w++) begin
            clear_all();
            model_word(pd[w], int'(pm[w]));
            push_word(pd[w], pm[w], ok, acc);
            repeat (20) @(negedge clk_i);
            vectors++;
            if (!ok || obs_bit.size() != exp_bit.size()) begin
                miscompares++;
                $display("FAIL pattern%0d_len: accepted=%0d bits=%0d, required 1/%0d",
                         w, ok, obs_bit.size(), exp_bit.size());
            end else begin
                for (int k = 0; k < exp_bit.size(); k++) begin
                    vectors++;
                    if (obs_bit[k] !== exp_bit[k] || obs_busy[k] !== exp_busy[k] || obs_cyc[k] != acc + 1 + k) begin
                        miscompares++;
                        $display("FAIL pattern%0d_bit%0d: bit=%b busy=%b cyc=%0d, required %b/%b/%0d",
                                 w, k, obs_bit[k], obs_busy[k], obs_cyc[k], exp_bit[k], exp_busy[k], acc + 1 + k);
                    end
                end
            end
        end
        vectors++;
        if (ready_o !== 1'b1 || ser_data_val_o !== 1'b0) begin
            miscompares++;
            $display("FAIL pattern_idle_after: ready=%b val=%b, required 1/0", ready_o, ser_data_val_o);
        end
    endtask

    task automatic test_mod_edges();
        logic [15:0] d20;
        bit ok1, ok2, ok3;
        int a1, a2, a3;
        clear_all();
        model_word(16'hFFFF, 1);
        model_word(16'h8000, 2);
        push_word(16'hFFFF, 5'd1, ok1, a1);
        push_word(16'h8000, 5'd2, ok2, a2);
        repeat (10) @(negedge clk_i);
        vectors++;
        if (!ok1 || !ok2 || obs_bit.size() != 2) begin
            miscompares++;
            $display("FAIL mod1_mod2_len: accepted=%0d%0d bits=%0d, required 11/2", ok1, ok2, obs_bit.size());
        end else begin
            vectors++;
            if (obs_bit[0] !== 1'b1 || obs_bit[1] !== 1'b0 || obs_busy[0] !== 1'b1 || obs_busy[1] !== 1'b0
                || obs_cyc[0] != a2 + 1) begin
                miscompares++;
                $display("FAIL mod2_bits: bits=%b%b busy=%b%b cyc0=%0d, required 10/10/%0d",
                         obs_bit[0], obs_bit[1], obs_busy[0], obs_busy[1], obs_cyc[0], a2 + 1);
            end
        end
        clear_all();
        d20 = 16'($urandom);
        model_word(d20, 20);
        push_word(d20, 5'd20, ok3, a3);
        repeat (20) @(negedge clk_i);
        vectors++;
        if (!ok3 || obs_bit.size() != 16) begin
            miscompares++;
            $display("FAIL mod20_len: accepted=%0d bits=%0d, required 1/16", ok3, obs_bit.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                vectors++;
                if (obs_bit[k] !== exp_bit[k] || obs_busy[k] !== exp_busy[k]) begin
                    miscompares++;
                    $display("FAIL mod20_bit%0d: bit=%b busy=%b, required %b/%b",
                             k, obs_bit[k], obs_busy[k], exp_bit[k], exp_busy[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int acc;
        bit seen5;
        clear_all();
        model_word(16'h5A3C, 0);
        push_word(16'h5A3C, 5'd0, ok, acc);
        seen5 = 1'b0;
        for (int t = 0; t < 40 && !seen5; t++) begin
            @(negedge clk_i);
            if (obs_bit.size() == 5) seen5 = 1'b1;
        end
        vectors++;
        if (!ok || !seen5) begin
            miscompares++;
            $display("FAIL rstmid_reach_bit5: accepted=%0d reached=%0d, required 1/1", ok, seen5);
        end
        #2;
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({ser_data_o, ser_data_val_o, busy_o, ready_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstmid_outputs: data/val/busy/ready=%b, required 0000",
                     {ser_data_o, ser_data_val_o, busy_o, ready_o});
        end
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        clear_all();
        model_word(16'hE1C3, 7);
        push_word(16'hE1C3, 5'd7, ok, acc);
        repeat (12) @(negedge clk_i);
        vectors++;
        if (!ok || obs_bit.size() != 7) begin
            miscompares++;
            $display("FAIL rstmid_after_len: accepted=%0d bits=%0d, required 1/7", ok, obs_bit.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                vectors++;
                if (obs_bit[k] !== exp_bit[k] || obs_busy[k] !== exp_busy[k] || obs_cyc[k] != acc + 1 + k) begin
                    miscompares++;
                    $display("FAIL rstmid_after_bit%0d: bit=%b busy=%b cyc=%0d, required %b/%b/%0d",
                             k, obs_bit[k], obs_busy[k], obs_cyc[k], exp_bit[k], exp_busy[k], acc + 1 + k);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [4:0]  m;
        bit ok;
        int acc;
        clear_all();
        for (int i = 0; i < 30; i++) begin
            d = 16'($urandom);
            m = 5'($urandom_range(0, 31));
            model_word(d, int'(m));
            push_word(d, m, ok, acc);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL random_accept%0d: no ready within budget, required accept", i);
            end
        end
        repeat (40) @(negedge clk_i);
        vectors++;
        if (obs_bit.size() != exp_bit.size()) begin
            miscompares++;
            $display("FAIL random_len: bits=%0d, required %0d", obs_bit.size(), exp_bit.size());
        end else begin
            for (int k = 0; k < exp_bit.size(); k++) begin
                vectors++;
                if (obs_bit[k] !== exp_bit[k] || obs_busy[k] !== exp_busy[k]) begin
                    miscompares++;
                    $display("FAIL random_bit%0d: bit=%b busy=%b, required %b/%b",
                             k, obs_bit[k], obs_busy[k], exp_bit[k], exp_busy[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        int a1, a2;
        int gap;
        bit exp_rdy;
`ifdef SERIAL_HOLD_BUF_EN
        gap = 1;
`else
        gap = 2;
`endif
        clear_all();
        model_word(16'hB000, 4);
        model_word(16'h6000, 4);
        push_word(16'hB000, 5'd4, ok1, a1);
        push_word(16'h6000, 5'd4, ok2, a2);
        repeat (15) @(negedge clk_i);
        vectors++;
        if (!ok1 || !ok2 || obs_bit.size() != 8) begin
            miscompares++;
            $display("FAIL b2b_len: accepted=%0d%0d bits=%0d, required 11/8", ok1, ok2, obs_bit.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if (obs_bit[k] !== exp_bit[k] || obs_busy[k] !== exp_busy[k]
                    || obs_cyc[k] != a1 + 1 + k + ((k >= 4) ? gap - 1 : 0)) begin
                    miscompares++;
                    $display("FAIL b2b_bit%0d: bit=%b busy=%b cyc=%0d, required %b/%b/%0d", k, obs_bit[k],
                             obs_busy[k], obs_cyc[k], exp_bit[k], exp_busy[k], a1 + 1 + k + ((k >= 4) ? gap - 1 : 0));
                end
            end
            for (int c = a1 + 1; c <= a1 + 5; c++) begin
`ifdef SERIAL_HOLD_BUF_EN
                exp_rdy = !(c >= a1 + 2 && c <= a1 + 4);
`else
                exp_rdy = (c == a1 + 5);
`endif
                vectors++;
                if (!rdy_hist.exists(c) || rdy_hist[c] !== exp_rdy) begin
                    miscompares++;
                    $display("FAIL b2b_ready_cyc%0d: ready=%b, required %b", c,
                             rdy_hist.exists(c) ? rdy_hist[c] : 1'bx, exp_rdy);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_patterns();
        test_mod_edges();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
